paj7620_i2c_slave: RTL and testbench

//  I2C target (responder) emulating the PAJ7620 gesture sensor register map, used as the
//  far end of the existing PAJ7620 I2C master for on-board loopback and bench bring-up.

---
 rtl/paj7620_i2c_slave_if.sv | 12 +
 rtl/paj7620_i2c_slave.sv | 243 ++++++++++++++++++++++++
 tb/tb_paj7620_i2c_slave.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/paj7620_i2c_slave_if.sv
// Gesture-event and status signals of the PAJ7620 I2C target emulator.
// The I2C lines (scl/sda) stay plain ports because sda is an open-drain inout.
`timescale 1ns/1ps
interface paj7620_i2c_slave_if;
  logic       gest_vld;
  logic [2:0] gest_code;
  logic       bank_sel;
  logic       busy;

  modport slave  (input gest_vld, gest_code, output bank_sel, busy);
  modport master (output gest_vld, gest_code, input bank_sel, busy);
endinterface

// File: rtl/paj7620_i2c_slave.sv
// PAJ7620 gesture-sensor register map behind an I2C target, sampled with sys_clk.
// Optional bus-abort on a stuck-low scl is enabled with `define PAJ_SLV_TIMEOUT_EN.
`timescale 1ns/1ps
module paj7620_i2c_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h73,
  parameter int         FILT_LEN = 3
`ifdef PAJ_SLV_TIMEOUT_EN
  , parameter int       TIMEOUT_CYC = 1_250_000
`endif
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               scl,
  inout  wire                sda,
  paj7620_i2c_slave_if.slave ev
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_REG, S_REG_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
  } state_t;

  // Register map read mux; bank 1 only exposes the bank-select register.
  function automatic logic [7:0] rd_reg(input logic [7:0] a, input logic bank,
                                        input logic [7:0] flags);
    logic [7:0] v;
    v = 8'h00;
    if (a == 8'hEF) v = {7'd0, bank};
    else if (!bank) begin
      case (a)
        8'h00:   v = 8'h20;
        8'h01:   v = 8'h76;
        8'h43:   v = flags;
        default: v = 8'h00;
      endcase
    end
    return v;
  endfunction

  logic [1:0]          scl_sync_q, sda_sync_q;
  logic [FILT_LEN-1:0] scl_hist_q, sda_hist_q;
  logic                scl_f_q, sda_f_q;
  logic                scl_f, sda_f;
  logic                scl_rise, scl_fall, start_det, stop_det;

  // A level is accepted only after FILT_LEN equal synchronised samples.
  assign scl_f = (&scl_hist_q) ? 1'b1 : ((|scl_hist_q) ? scl_f_q : 1'b0);
  assign sda_f = (&sda_hist_q) ? 1'b1 : ((|sda_hist_q) ? sda_f_q : 1'b0);
  assign scl_rise  =  scl_f & ~scl_f_q;
  assign scl_fall  = ~scl_f &  scl_f_q;
  assign start_det =  scl_f & scl_f_q & ~sda_f &  sda_f_q;
  assign stop_det  =  scl_f & scl_f_q &  sda_f & ~sda_f_q;

  // Two-flop synchroniser followed by the glitch-filter history; idle bus is high.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= '1;
      sda_hist_q <= '1;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl};
      sda_sync_q <= {sda_sync_q[0], sda};
      scl_hist_q <= {scl_hist_q[FILT_LEN-2:0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[FILT_LEN-2:0], sda_sync_q[1]};
      scl_f_q    <= scl_f;
      sda_f_q    <= sda_f;
    end
  end

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, ptr_q, ptr_d, snap_q, snap_d, flag_q, flag_d;
  logic       oe_q, oe_d, busy_q, busy_d, rw_q, rw_d, ack_q, ack_d;
  logic       snap_flag_q, snap_flag_d, bank_q, bank_d;
  logic       to_hit;

`ifdef PAJ_SLV_TIMEOUT_EN
  logic [31:0] to_cnt_q;
  assign to_hit = (to_cnt_q == 32'(TIMEOUT_CYC - 1)) && !scl_f && (state_q != S_IDLE);

  // Count consecutive scl-low cycles while a transfer is in progress.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) to_cnt_q <= '0;
    else if (state_q == S_IDLE || scl_f || to_hit) to_cnt_q <= '0;
    else to_cnt_q <= to_cnt_q + 32'd1;
  end
`else
  assign to_hit = 1'b0;
`endif

  // Protocol state register and all transaction-held state.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      ptr_q       <= '0;
      snap_q      <= '0;
      flag_q      <= '0;
      oe_q        <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
      ack_q       <= 1'b0;
      snap_flag_q <= 1'b0;
      bank_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      ptr_q       <= ptr_d;
      snap_q      <= snap_d;
      flag_q      <= flag_d;
      oe_q        <= oe_d;
      busy_q      <= busy_d;
      rw_q        <= rw_d;
      ack_q       <= ack_d;
      snap_flag_q <= snap_flag_d;
      bank_q      <= bank_d;
    end
  end

  logic       ld;
  logic [7:0] ld_addr, ld_val, flag_clr, flag_set;

  // Next-state decode: bits captured on filtered scl rise, sda moved only on scl fall.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    ptr_d       = ptr_q;
    snap_d      = snap_q;
    oe_d        = oe_q;
    busy_d      = busy_q;
    rw_d        = rw_q;
    ack_d       = ack_q;
    snap_flag_d = snap_flag_q;
    bank_d      = bank_q;
    ld          = 1'b0;
    ld_addr     = ptr_q;
    flag_clr    = 8'h00;
    flag_set    = ev.gest_vld ? (8'd1 << ev.gest_code) : 8'h00;

    if (stop_det || to_hit) begin
      state_d = S_IDLE;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
    end else if (start_det) begin
      state_d = S_ADDR;
      cnt_d   = '0;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        S_ADDR, S_REG, S_WDATA: begin
          if (scl_rise) begin
            sh_d  = {sh_q[6:0], sda_f};
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            oe_d = 1'b1;
            if (state_q == S_ADDR) begin
              if (sh_q[7:1] == DEV_ADDR) begin
                rw_d    = sh_q[0];
                busy_d  = 1'b1;
                state_d = S_ADDR_ACK;
              end else begin
                oe_d    = 1'b0;
                busy_d  = 1'b0;
                state_d = S_WAIT_STOP;
              end
            end else if (state_q == S_REG) begin
              ptr_d   = sh_q;
              state_d = S_REG_ACK;
            end else begin
              if (ptr_q == 8'hEF) bank_d = sh_q[0];
              ptr_d   = ptr_q + 8'd1;
              state_d = S_WDATA_ACK;
            end
          end
        end
        S_ADDR_ACK, S_REG_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            cnt_d = '0;
            oe_d  = 1'b0;
            if (state_q == S_ADDR_ACK && rw_q) begin
              ld      = 1'b1;
              state_d = S_RDATA;
            end else begin
              state_d = (state_q == S_ADDR_ACK) ? S_REG : S_WDATA;
            end
          end
        end
        S_RDATA: begin
          if (scl_rise) cnt_d = cnt_q + 4'd1;
          else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              oe_d    = 1'b0;
              state_d = S_RDATA_ACK;
            end else begin
              sh_d = {sh_q[6:0], 1'b0};
              oe_d = ~sh_q[6];
            end
          end
        end
        S_RDATA_ACK: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
            ack_d = ~sda_f;
            if (snap_flag_q) flag_clr = snap_q;
          end else if (scl_fall && cnt_q == 4'd9) begin
            cnt_d = '0;
            if (ack_q) begin
              ptr_d   = ptr_q + 8'd1;
              ld      = 1'b1;
              ld_addr = ptr_q + 8'd1;
              state_d = S_RDATA;
            end else begin
              busy_d  = 1'b0;
              state_d = S_WAIT_STOP;
            end
          end
        end
        default: ;
      endcase
    end

    ld_val = rd_reg(ld_addr, bank_q, flag_q);
    if (ld) begin
      sh_d        = ld_val;
      snap_d      = ld_val;
      snap_flag_d = (ld_addr == 8'h43) && !bank_q;
      oe_d        = ~ld_val[7];
    end

    flag_d = (flag_q & ~flag_clr) | flag_set;
  end

  assign sda         = oe_q ? 1'b0 : 1'bz;
  assign ev.bank_sel = bank_q;
  assign ev.busy     = busy_q;

endmodule

// File: tb/tb_paj7620_i2c_slave.sv
// Bench for paj7620_i2c_slave: a bit-banged I2C master issues transfers and pushes
// the expected 9-bit frames; an independent bus monitor decodes frames and scores them.
`timescale 1ns/1ps
module tb_paj7620_i2c_slave;
  localparam int H = 20;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic scl_m     = 1'b1;
  logic sda_low   = 1'b0;
  wire  sda;

  pullup (sda);
  assign sda = sda_low ? 1'b0 : 1'bz;

  paj7620_i2c_slave_if gif();

`ifdef PAJ_SLV_TIMEOUT_EN
  paj7620_i2c_slave #(.DEV_ADDR(7'h73), .FILT_LEN(3), .TIMEOUT_CYC(100)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .scl(scl_m), .sda(sda), .ev(gif));
`else
  paj7620_i2c_slave #(.DEV_ADDR(7'h73), .FILT_LEN(3)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .scl(scl_m), .sda(sda), .ev(gif));
`endif

  always #10 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0] data;
    logic       ack;
    int         id;
  } frame_t;

  frame_t exp_q[$];
  int     frame_id = 0;
  int     tests    = 0;
  int     fails    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor: decodes START/STOP and 9-bit frames from the wires, scores each frame.
  logic       mon_scl_p = 1'b1, mon_sda_p = 1'b1, mon_in = 1'b0;
  logic [8:0] mon_bits  = '0;
  int         mon_n     = 0;
  always begin
    logic scl_n, sda_n;
    frame_t e;
    @(negedge sys_clk);
    #5;
    scl_n = scl_m;
    sda_n = sda;
    if (scl_n && mon_scl_p && mon_sda_p && !sda_n) begin
      mon_in = 1'b1;
      mon_n  = 0;
    end else if (scl_n && mon_scl_p && !mon_sda_p && sda_n) begin
      mon_in = 1'b0;
    end else if (scl_n && !mon_scl_p && mon_in) begin
      mon_bits = {mon_bits[7:0], sda_n};
      mon_n++;
      if (mon_n == 9) begin
        mon_n = 0;
        if (exp_q.size() == 0) check("unexpected_frame", 32'(mon_bits), 32'h3FF);
        else begin
          e = exp_q.pop_front();
          check($sformatf("frame%0d", e.id), 32'(mon_bits), 32'({e.data, e.ack}));
        end
      end
    end
    mon_scl_p = scl_n;
    mon_sda_p = sda_n;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic push(input logic [7:0] d, input logic a);
    frame_t f;
    f.data = d;
    f.ack  = a;
    f.id   = frame_id++;
    exp_q.push_back(f);
  endtask

  task automatic bus_start();
    sda_low = 1'b1; cyc(H); scl_m = 1'b0;
  endtask

  task automatic bus_rstart();
    cyc(5); sda_low = 1'b0; cyc(H - 5); scl_m = 1'b1; cyc(H);
    sda_low = 1'b1; cyc(H); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    cyc(5); sda_low = 1'b1; cyc(H - 5); scl_m = 1'b1; cyc(H);
    sda_low = 1'b0; cyc(H);
  endtask

  task automatic send_bit(input logic b);
    cyc(5); sda_low = ~b; cyc(H - 5); scl_m = 1'b1; cyc(H); scl_m = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] b, input logic exp_nack);
    push(b, exp_nack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(1'b1);
  endtask

  // Reads one byte; inj holds gest_vld (code 0) around the 9th scl rise.
  task automatic rd_byte(input logic [7:0] exp, input logic nack, input logic inj);
    push(exp, nack);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    cyc(5); sda_low = ~nack; cyc(H - 5); scl_m = 1'b1;
    if (inj) begin
      gif.gest_code = 3'd0; gif.gest_vld = 1'b1;
      cyc(12);
      gif.gest_vld = 1'b0;
      cyc(H - 12);
    end else cyc(H);
    scl_m = 1'b0;
  endtask

  task automatic pulse(input logic [2:0] code);
    gif.gest_code = code; gif.gest_vld = 1'b1; cyc(1); gif.gest_vld = 1'b0; cyc(1);
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
    bus_start(); wr_byte(8'hE6, 1'b0); wr_byte(a, 1'b0); wr_byte(d, 1'b0); bus_stop();
  endtask

  task automatic reg_read(input logic [7:0] a, input logic [7:0] exp, input logic inj);
    bus_start(); wr_byte(8'hE6, 1'b0); wr_byte(a, 1'b0);
    bus_rstart(); wr_byte(8'hE7, 1'b0); rd_byte(exp, 1'b1, inj); bus_stop();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    gif.gest_vld  = 1'b0;
    gif.gest_code = 3'd0;
    cyc(5);
    sys_rst_n = 1'b1;
    cyc(5);
    check("rst_bank", 32'(gif.bank_sel), 32'd0);
    check("rst_busy", 32'(gif.busy), 32'd0);
    check("rst_sda", 32'(sda), 32'd1);

    // Bank select write, busy during transfer.
    bus_start(); wr_byte(8'hE6, 1'b0);
    check("busy_after_ack", 32'(gif.busy), 32'd1);
    wr_byte(8'hEF, 1'b0); wr_byte(8'h01, 1'b0); bus_stop();
    check("bank_set", 32'(gif.bank_sel), 32'd1);
    check("busy_after_stop", 32'(gif.busy), 32'd0);

    // Bank 1 reads: part ID hidden, bank register visible.
    reg_read(8'h00, 8'h00, 1'b0);
    reg_read(8'hEF, 8'h01, 1'b0);
    reg_write(8'hEF, 8'h00);
    check("bank_clr", 32'(gif.bank_sel), 32'd0);

    // Burst read of part ID, released after NACK.
    bus_start(); wr_byte(8'hE6, 1'b0); wr_byte(8'h00, 1'b0);
    bus_rstart(); wr_byte(8'hE7, 1'b0); rd_byte(8'h20, 1'b0, 1'b0); rd_byte(8'h76, 1'b1, 1'b0);
    cyc(10);
    check("sda_after_nack", 32'(sda), 32'd1);
    check("busy_after_nack", 32'(gif.busy), 32'd0);
    bus_stop();

    // Gesture flags, clear-on-read.
    pulse(3'd2); pulse(3'd5);
    reg_read(8'h43, 8'h24, 1'b0);
    reg_read(8'h43, 8'h00, 1'b0);

    // New event coincident with clear survives.
    pulse(3'd2);
    reg_read(8'h43, 8'h04, 1'b1);
    reg_read(8'h43, 8'h01, 1'b0);

    // Wrong address: no ACK, not busy.
    bus_start(); wr_byte(8'hA4, 1'b1);
    check("busy_wrong_addr", 32'(gif.busy), 32'd0);
    bus_stop();

    // Repeated START mid data byte discards the partial write.
    bus_start(); wr_byte(8'hE6, 1'b0); wr_byte(8'hEF, 1'b0);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    bus_rstart(); wr_byte(8'hE7, 1'b0); rd_byte(8'h00, 1'b1, 1'b0); bus_stop();
    check("bank_no_partial", 32'(gif.bank_sel), 32'd0);

    // Burst write auto-increment into 0xEF, then pointer wrap on read.
    bus_start(); wr_byte(8'hE6, 1'b0); wr_byte(8'hEE, 1'b0);
    wr_byte(8'h00, 1'b0); wr_byte(8'h01, 1'b0); bus_stop();
    check("bank_burst", 32'(gif.bank_sel), 32'd1);
    reg_write(8'hEF, 8'h00);
    bus_start(); wr_byte(8'hE6, 1'b0); wr_byte(8'hFF, 1'b0);
    bus_rstart(); wr_byte(8'hE7, 1'b0); rd_byte(8'h00, 1'b0, 1'b0); rd_byte(8'h20, 1'b1, 1'b0);
    bus_stop();

`ifdef PAJ_SLV_TIMEOUT_EN
    // scl stuck low mid-read: target aborts and releases the bus.
    bus_start(); wr_byte(8'hE6, 1'b0); wr_byte(8'h00, 1'b0);
    bus_rstart(); wr_byte(8'hE7, 1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    cyc(150);
    check("timeout_sda", 32'(sda), 32'd1);
    check("timeout_busy", 32'(gif.busy), 32'd0);
    bus_stop();
`endif

    cyc(50);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
